if_id_skid_reg: RTL and testbench

IF_ID_SKID_REG -- requirements
Module: if_id_skid_reg

---
 rtl/if_id_skid_reg.sv | 128 ++++++++++++
 tb/tb_if_id_skid_reg.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer so that In_Ready is fully registered.
// Also counts back-pressure cycles in a saturating counter.
module if_id_skid_reg #(
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        PC_W      = 32,
  parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(32'h0000_0000),
  parameter int unsigned        CNT_W     = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] Instruction_In,
  input  logic [PC_W-1:0]   PC_In,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Instruction_Out,
  output logic [PC_W-1:0]   PC_Out,
  output logic [CNT_W-1:0]  Stall_Count
);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [PC_W-1:0]   pc;
  } entry_t;

  // EMPTY: no entry; MAIN: main slot valid; FULL: main and skid slots valid
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam entry_t NOP_ENTRY = '{instr: NOP_INSTR, pc: PC_W'(0)};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_n;
  entry_t           main_q, main_n;
  entry_t           skid_q, skid_n;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_n;
  logic             in_ready_q, in_ready_n;
  logic             out_valid_q, out_valid_n;
  logic             accept_c;
  logic             drain_c;
  entry_t           in_entry_c;

  assign in_entry_c = '{instr: Instruction_In, pc: PC_In};
  assign accept_c   = In_Valid & in_ready_q;
  assign drain_c    = out_valid_q & Out_Ready;

  // Next-state, slot contents and stall counter
  always_comb begin
    state_n     = state_q;
    main_n      = main_q;
    skid_n      = skid_q;
    stall_cnt_n = stall_cnt_q;

    // Back-pressure is counted even in a flush cycle; flush with Out_Ready=1 is not a stall
    if (out_valid_q && !Out_Ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_n = stall_cnt_q + CNT_W'(1);
    end

    if (Flush) begin
      state_n = ST_EMPTY;
      main_n  = NOP_ENTRY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            state_n = ST_MAIN;
            main_n  = in_entry_c;
          end
        end
        ST_MAIN: begin
          if (drain_c && accept_c) begin
            main_n = in_entry_c;
          end else if (drain_c) begin
            state_n = ST_EMPTY;
            main_n  = NOP_ENTRY;
          end else if (accept_c) begin
            state_n = ST_FULL;
            skid_n  = in_entry_c;
          end
        end
        ST_FULL: begin
          // In_Ready is low here, so only a drain can happen
          if (drain_c) begin
            state_n = ST_MAIN;
            main_n  = skid_q;
          end
        end
        default: begin
          state_n = ST_EMPTY;
          main_n  = NOP_ENTRY;
        end
      endcase
    end

    in_ready_n  = (state_n != ST_FULL);
    out_valid_n = (state_n != ST_EMPTY);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= NOP_ENTRY;
      skid_q      <= NOP_ENTRY;
      stall_cnt_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      main_q      <= main_n;
      skid_q      <= skid_n;
      stall_cnt_q <= stall_cnt_n;
      in_ready_q  <= in_ready_n;
      out_valid_q <= out_valid_n;
    end
  end

  assign In_Ready        = in_ready_q;
  assign Out_Valid       = out_valid_q;
  assign Instruction_Out = main_q.instr;
  assign PC_Out          = main_q.pc;
  assign Stall_Count     = stall_cnt_q;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed and random bench for if_id_skid_reg; an in-order queue models the two slots.
module tb_if_id_skid_reg;

  logic        Clk;
  logic        Rst;
  logic        Flush;
  logic        In_Valid;
  logic [31:0] Instruction_In;
  logic [31:0] PC_In;
  logic        Out_Ready;

  logic        In_Ready, Out_Valid;
  logic [31:0] Instruction_Out, PC_Out;
  logic [15:0] Stall_Count;

  logic        In_Ready3, Out_Valid3;
  logic [31:0] Instruction_Out3, PC_Out3;
  logic [2:0]  Stall_Count3;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t      q[$];
  logic [15:0] stall_m;
  logic [2:0]  stall3_m;
  int          nchecks;
  int          nerrs;

  if_id_skid_reg dut (
    .Clk(Clk), .Rst(Rst), .Flush(Flush),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Instruction_In(Instruction_In), .PC_In(PC_In),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Instruction_Out(Instruction_Out), .PC_Out(PC_Out),
    .Stall_Count(Stall_Count)
  );

  if_id_skid_reg #(.CNT_W(3)) dut3 (
    .Clk(Clk), .Rst(Rst), .Flush(Flush),
    .In_Valid(In_Valid), .In_Ready(In_Ready3),
    .Instruction_In(Instruction_In), .PC_In(PC_In),
    .Out_Valid(Out_Valid3), .Out_Ready(Out_Ready),
    .Instruction_Out(Instruction_Out3), .PC_Out(PC_Out3),
    .Stall_Count(Stall_Count3)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return 32'h1300_0000 | pc;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare both DUTs against the queue model (state before the coming edge)
  task automatic check_outputs();
    logic ov_m;
    logic ir_m;
    ov_m = (q.size() != 0);
    ir_m = (q.size() < 2);
    chk("out_valid", 64'(Out_Valid), 64'(ov_m));
    chk("in_ready", 64'(In_Ready), 64'(ir_m));
    chk("in_ready3", 64'(In_Ready3), 64'(ir_m));
    if (ov_m) begin
      chk("pc_out", 64'(PC_Out), 64'(q[0].pc));
      chk("instr_out", 64'(Instruction_Out), 64'(q[0].instr));
      chk("pc_out3", 64'(PC_Out3), 64'(q[0].pc));
    end else begin
      chk("pc_out_empty", 64'(PC_Out), 64'd0);
      chk("instr_out_nop", 64'(Instruction_Out), 64'd0);
      chk("instr_out3_nop", 64'(Instruction_Out3), 64'd0);
    end
    chk("stall_count", 64'(Stall_Count), 64'(stall_m));
    chk("stall_count3", 64'(Stall_Count3), 64'(stall3_m));
  endtask

  task automatic step(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
    logic ov_m;
    logic ir_m;
    entry_t e;
    @(negedge Clk);
    In_Valid       = iv;
    PC_In          = pc;
    Instruction_In = mk_instr(pc);
    Out_Ready      = ordy;
    Flush          = fl;
    #1;
    check_outputs();
    ov_m = (q.size() != 0);
    ir_m = (q.size() < 2);
    if (ov_m && !ordy) begin
      if (stall_m != 16'hFFFF) stall_m++;
      if (stall3_m != 3'd7) stall3_m++;
    end
    if (fl) begin
      q.delete();
    end else begin
      if (ov_m && ordy) void'(q.pop_front());
      if (iv && ir_m) begin
        e.instr = mk_instr(pc);
        e.pc    = pc;
        q.push_back(e);
      end
    end
  endtask

  task automatic check_reset_state();
    chk("rst_out_valid", 64'(Out_Valid), 64'd0);
    chk("rst_in_ready", 64'(In_Ready), 64'd1);
    chk("rst_pc_out", 64'(PC_Out), 64'd0);
    chk("rst_instr_nop", 64'(Instruction_Out), 64'd0);
    chk("rst_stall", 64'(Stall_Count), 64'd0);
    chk("rst_stall3", 64'(Stall_Count3), 64'd0);
    chk("rst_in_ready3", 64'(In_Ready3), 64'd1);
  endtask

  initial begin
    nchecks = 0;
    nerrs = 0;
    stall_m = '0;
    stall3_m = '0;
    Rst = 1'b1;
    Flush = 1'b0;
    In_Valid = 1'b0;
    Instruction_In = '0;
    PC_In = '0;
    Out_Ready = 1'b0;
    #1;
    check_reset_state();
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;

    // Streaming at one entry per cycle
    step(1'b1, 32'h00, 1'b1, 1'b0);
    step(1'b1, 32'h04, 1'b1, 1'b0);
    step(1'b1, 32'h08, 1'b1, 1'b0);
    step(1'b0, 32'h00, 1'b1, 1'b0);
    step(1'b0, 32'h00, 1'b1, 1'b0);

    // Back-pressure into the skid slot, then release
    step(1'b1, 32'h10, 1'b1, 1'b0);
    step(1'b1, 32'h14, 1'b0, 1'b0);
    step(1'b0, 32'h00, 1'b0, 1'b0);
    step(1'b0, 32'h00, 1'b0, 1'b0);
    step(1'b0, 32'h00, 1'b1, 1'b0);
    step(1'b0, 32'h00, 1'b1, 1'b0);
    step(1'b0, 32'h00, 1'b1, 1'b0);

    // Flush with both slots full and a new offer in the same cycle
    step(1'b1, 32'h20, 1'b1, 1'b0);
    step(1'b1, 32'h24, 1'b0, 1'b0);
    step(1'b1, 32'h28, 1'b0, 1'b1);
    step(1'b0, 32'h00, 1'b1, 1'b0);
    step(1'b0, 32'h00, 1'b1, 1'b0);

    // Flush with Out_Ready high is neither a drain nor a stall
    step(1'b1, 32'h30, 1'b1, 1'b0);
    step(1'b0, 32'h00, 1'b1, 1'b1);
    step(1'b0, 32'h00, 1'b1, 1'b0);

    // Asynchronous reset between edges with both slots full
    step(1'b1, 32'h40, 1'b0, 1'b0);
    step(1'b1, 32'h44, 1'b0, 1'b0);
    step(1'b0, 32'h00, 1'b0, 1'b0);
    @(negedge Clk);
    In_Valid = 1'b0;
    Out_Ready = 1'b0;
    Rst = 1'b1;
    #1;
    check_reset_state();
    #2;
    Rst = 1'b0;
    q.delete();
    stall_m = '0;
    stall3_m = '0;
    step(1'b1, 32'h48, 1'b1, 1'b0);
    step(1'b0, 32'h00, 1'b1, 1'b0);
    step(1'b0, 32'h00, 1'b1, 1'b0);

    // Saturation of the 3-bit counter over 10 held cycles
    step(1'b1, 32'h50, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h00, 1'b0, 1'b0);
    step(1'b0, 32'h00, 1'b1, 1'b0);
    chk("stall3_saturated", 64'(Stall_Count3), 64'd7);
    step(1'b0, 32'h00, 1'b1, 1'b0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), 32'h100 + 32'(i * 4),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 32'h00, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
